// File: rtl/fan_speed_ctrl.sv
// Incubator cooler fan controller: signed temperature to one of LEVELS speeds plus OFF,
// with per-level hysteresis, a minimum dwell between changes and an over-temperature alarm.
module fan_speed_ctrl #(
  parameter int T_W      = 8,
  parameter int LEVELS   = 3,
  parameter int T_ON     = 35,
  parameter int T_OFF    = 25,
  parameter int STEP     = 5,
  parameter int HYST     = 5,
  parameter int CRS_W    = 4,
  parameter int CRS_BASE = 4,
  parameter int CRS_STEP = 2,
  parameter int DWELL    = 16,
  parameter int T_ALARM  = 50
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              Cooler,
  input  logic signed [T_W-1:0]             T,
  output logic        [CRS_W-1:0]           CRS,
  output logic                              OUT,
  output logic        [$clog2(LEVELS+1)-1:0] LEVEL,
  output logic                              CHG,
  output logic                              ALARM
);

  localparam int LW = $clog2(LEVELS + 1);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int TX = T_W + 4;

  typedef logic signed [TX-1:0] temp_t;

  logic [LW-1:0]    level_q, level_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CRS_W-1:0] crs_q, crs_d;
  logic             out_q, out_d;
  logic             chg_q, chg_d;
  logic             alarm_q, alarm_d;

  temp_t t_ext, up_thr, dn_thr, al_hi, al_lo;
  logic  go_up, go_dn;

  always_comb begin
    t_ext  = {{4{T[T_W-1]}}, T};
    al_hi  = temp_t'(T_ALARM);
    al_lo  = temp_t'(T_ALARM - HYST);
    up_thr = temp_t'(T_ON + int'(level_q) * STEP);
    // Level 1 falls back on its own OFF threshold; higher levels use the hysteresis band.
    dn_thr = (level_q == LW'(1)) ? temp_t'(T_OFF)
                                 : temp_t'(T_ON + (int'(level_q) - 1) * STEP - HYST);
    go_up  = (int'(level_q) < LEVELS) && (t_ext > up_thr);
    go_dn  = (level_q != '0) && (t_ext < dn_thr);

    level_d = level_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

    if (!Cooler) begin
      level_d = '0;
      cnt_d   = '0;
    end else if (cnt_q == '0) begin
      if (go_up) begin
        level_d = level_q + LW'(1);
        cnt_d   = CW'(DWELL - 1);
      end else if (go_dn) begin
        level_d = level_q - LW'(1);
        cnt_d   = CW'(DWELL - 1);
      end
    end

    // Alarm only arms once the top level has been held; leaving the top level clears it.
    alarm_d = alarm_q;
    if (!Cooler || level_d != LW'(LEVELS)) begin
      alarm_d = 1'b0;
    end else if (level_q == LW'(LEVELS) && t_ext > al_hi) begin
      alarm_d = 1'b1;
    end else if (t_ext < al_lo) begin
      alarm_d = 1'b0;
    end

    chg_d = (level_d != level_q);
    out_d = (level_d == '0);
    crs_d = (level_d == '0) ? '0 : CRS_W'(CRS_BASE + (int'(level_d) - 1) * CRS_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      cnt_q   <= '0;
      crs_q   <= '0;
      out_q   <= 1'b1;
      chg_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      crs_q   <= crs_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
      alarm_q <= alarm_d;
    end
  end

  assign LEVEL = level_q;
  assign CRS   = crs_q;
  assign OUT   = out_q;
  assign CHG   = chg_q;
  assign ALARM = alarm_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Self-checking bench for fan_speed_ctrl: directed scenarios plus random temperature sweeps
// compared against a threshold-table reference model.
module tb_fan_speed_ctrl;

  localparam int T_W      = 8;
  localparam int LEVELS   = 3;
  localparam int T_ON     = 35;
  localparam int T_OFF    = 25;
  localparam int STEP     = 5;
  localparam int HYST     = 5;
  localparam int CRS_W    = 4;
  localparam int CRS_BASE = 4;
  localparam int CRS_STEP = 2;
  localparam int DWELL    = 4;
  localparam int T_ALARM  = 50;
  localparam int LW       = $clog2(LEVELS + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  Cooler = 1'b0;
  logic signed [T_W-1:0] T = '0;
  logic [CRS_W-1:0]      CRS;
  logic                  OUT;
  logic [LW-1:0]         LEVEL;
  logic                  CHG;
  logic                  ALARM;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_level = 0;
  int m_cnt   = 0;
  bit m_chg   = 0;
  bit m_alarm = 0;
  int up_tab[0:LEVELS];
  int dn_tab[0:LEVELS];

  fan_speed_ctrl #(
    .T_W(T_W), .LEVELS(LEVELS), .T_ON(T_ON), .T_OFF(T_OFF), .STEP(STEP), .HYST(HYST),
    .CRS_W(CRS_W), .CRS_BASE(CRS_BASE), .CRS_STEP(CRS_STEP), .DWELL(DWELL), .T_ALARM(T_ALARM)
  ) dut (
    .clk(clk), .rst(rst), .Cooler(Cooler), .T(T),
    .CRS(CRS), .OUT(OUT), .LEVEL(LEVEL), .CHG(CHG), .ALARM(ALARM)
  );

  always #5 clk = ~clk;

  wire [LW+CRS_W+2:0] act = {LEVEL, CRS, OUT, CHG, ALARM};

  function automatic logic [LW+CRS_W+2:0] exp_vec();
    int crs;
    crs = (m_level == 0) ? 0 : (CRS_BASE + (m_level - 1) * CRS_STEP) % (1 << CRS_W);
    return {LW'(m_level), CRS_W'(crs), (m_level == 0), m_chg, m_alarm};
  endfunction

  // Up/down thresholds tabulated per level straight from the threshold rules.
  task automatic build_tables();
    for (int k = 0; k <= LEVELS; k++) begin
      up_tab[k] = (k < LEVELS) ? T_ON + k * STEP : 1000;
      dn_tab[k] = (k == 0) ? -1000 : (k == 1) ? T_OFF : T_ON + (k - 1) * STEP - HYST;
    end
  endtask

  task automatic tick(input bit r, input bit c, input int t);
    int nl;
    rst = r; Cooler = c; T = T_W'(t);
    @(posedge clk);
    nl = m_level;
    if (r) begin
      nl = 0; m_cnt = 0; m_alarm = 0;
    end else if (!c) begin
      nl = 0; m_cnt = 0; m_alarm = 0;
    end else begin
      if (m_cnt == 0) begin
        if (t > up_tab[m_level])      nl = m_level + 1;
        else if (t < dn_tab[m_level]) nl = m_level - 1;
      end
      if (nl != m_level)  m_cnt = DWELL - 1;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (nl != LEVELS)                               m_alarm = 0;
      else if (m_level == LEVELS && t > T_ALARM)      m_alarm = 1;
      else if (t < T_ALARM - HYST)                    m_alarm = 0;
    end
    m_chg   = !r && (nl != m_level);
    m_level = nl;
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, 0);
    total++;
    if (act !== {2'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset: got=%b want=%b", act, {2'd0, 4'd0, 3'b100});
    end
  endtask

  task automatic test_first_level();
    tick(0, 1, 36);
    total++;
    if (act !== {2'd1, 4'd4, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL first_level: got=%b want=%b", act, {2'd1, 4'd4, 3'b010});
    end
    tick(0, 1, 36);
    total++;
    if (act !== exp_vec() || CHG !== 1'b0) begin
      bad++; $display("FAIL first_level_hold: got=%b want=%b", act, exp_vec());
    end
  endtask

  task automatic test_climb();
    int last_chg = -1;
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, 46);
      total++;
      if (act !== exp_vec()) begin
        bad++; $display("FAIL climb[%0d]: got=%b want=%b", i, act, exp_vec());
      end
      if (CHG === 1'b1) begin
        total++;
        if (last_chg >= 0 && i - last_chg !== DWELL) begin
          bad++; $display("FAIL climb_spacing: got=%0d want=%0d", i - last_chg, DWELL);
        end
        last_chg = i;
      end
    end
    total++;
    if (LEVEL !== 2'd3 || CRS !== 4'd8) begin
      bad++; $display("FAIL climb_top: got=%0d/%0d want=3/8", LEVEL, CRS);
    end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 14; i++) begin
      tick(0, 1, 36);
      total++;
      if (act !== exp_vec()) begin
        bad++; $display("FAIL hyst_hold[%0d]: got=%b want=%b", i, act, exp_vec());
      end
    end
    total++;
    if (LEVEL !== 2'd2) begin
      bad++; $display("FAIL hyst_l2: got=%0d want=2", LEVEL);
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 34);
      total++;
      if (act !== exp_vec()) begin
        bad++; $display("FAIL hyst_drop[%0d]: got=%b want=%b", i, act, exp_vec());
      end
    end
    total++;
    if (LEVEL !== 2'd1) begin
      bad++; $display("FAIL hyst_l1: got=%0d want=1", LEVEL);
    end
  endtask

  task automatic test_cooler_off();
    while (m_level != LEVELS) tick(0, 1, 46);
    tick(0, 0, 46);
    total++;
    if (act !== {2'd0, 4'd0, 1'b1, 1'b1, 1'b0} || act !== exp_vec()) begin
      bad++; $display("FAIL cooler_off: got=%b want=%b", act, exp_vec());
    end
    tick(0, 1, 36);
    total++;
    if (act !== {2'd1, 4'd4, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL cooler_on: got=%b want=%b", act, {2'd1, 4'd4, 3'b010});
    end
  endtask

  task automatic test_alarm();
    int seq_t[$] = '{51, 51, 47, 47, 47, 44, 44};
    while (m_level != LEVELS) tick(0, 1, 46);
    foreach (seq_t[i]) begin
      tick(0, 1, seq_t[i]);
      total++;
      if (act !== exp_vec()) begin
        bad++; $display("FAIL alarm[%0d]: got=%b want=%b", i, act, exp_vec());
      end
    end
    total++;
    if (ALARM !== 1'b0 || LEVEL !== 2'd3) begin
      bad++; $display("FAIL alarm_clear: got=%b/%0d want=0/3", ALARM, LEVEL);
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 0);
    while (m_level != LEVELS) tick(0, 1, 51);
    tick(0, 1, 51);
    total++;
    if (ALARM !== 1'b1 || m_cnt == 0) begin
      bad++; $display("FAIL reset_mid_setup: got=%b want=1", ALARM);
    end
    tick(1, 1, 51);
    total++;
    if (act !== {2'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_mid: got=%b want=%b", act, {2'd0, 4'd0, 3'b100});
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, -128);
      total++;
      if (act !== exp_vec() || LEVEL !== 2'd0) begin
        bad++; $display("FAIL cold_no_wrap[%0d]: got=%b want=%b", i, act, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int t;
    bit c, r;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(199) == 0);
      c = ($urandom_range(49) != 0);
      if ($urandom_range(9) == 0) t = int'($urandom_range(255)) - 128;
      else                         t = int'($urandom_range(50)) + 15;
      tick(r, c, t);
      total++;
      if (act !== exp_vec()) begin
        bad++; $display("FAIL random[%0d]: t=%0d got=%b want=%b", i, t, act, exp_vec());
      end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_first_level();
    test_climb();
    test_hysteresis();
    test_cooler_off();
    test_alarm();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
